// File: rtl/vga_pattern_display.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pattern_display
//  Purpose  : Pixel-data generator for the VGA timing driver. Produces one of
//             four test patterns (colour bars, checkerboard, grey ramp,
//             bouncing box) from the driver's pixel coordinates. A debounced
//             push-button selects the pattern; pattern changes and box motion
//             take effect only on frame boundaries (Fsync falling edge).
//  Ports    : driver_clk        - pixel clock
//             sys_rst_n         - asynchronous active-low reset
//             pixel_xpos [9:0]  - column, 1..H_DISP active, 0 in blanking
//             pixel_ypos [9:0]  - row, 1..V_DISP active, 0 in blanking
//             Fsync             - vertical sync, active-low
//             key_n             - asynchronous push-button, pressed = 0
//             data_from_display - {R[29:20], G[19:10], B[9:0]}, registered
//             mode [1:0]        - currently displayed pattern
//  Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_display #(
  parameter int H_DISP          = 640,
  parameter int V_DISP          = 480,
  parameter int BOX_SIZE        = 32,
  parameter int BOX_STEP        = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        driver_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pixel_xpos,
  input  logic [9:0]  pixel_ypos,
  input  logic        Fsync,
  input  logic        key_n,
  output logic [29:0] data_from_display,
  output logic [1:0]  mode
);

  localparam int               c_CNT_W   = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0]      c_LIMIT_X = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0]      c_LIMIT_Y = 11'(V_DISP - BOX_SIZE);
  localparam logic [10:0]      c_STEP    = 11'(BOX_STEP);
  localparam logic [10:0]      c_SIZE    = 11'(BOX_SIZE);
  localparam int               c_BAR_W   = H_DISP / 8;
  localparam logic [9:0]       c_FULL    = 10'h3FF;

  // --------------------------------------------------------------------------
  // Key synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic               r_key_meta;
  logic               r_key_sync;
  logic               r_key_db;
  logic [c_CNT_W-1:0] r_db_cnt;
  logic               w_press;

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
      r_key_db   <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_key_meta <= key_n;
      r_key_sync <= r_key_meta;
      if (r_key_sync == r_key_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_CNT_MAX) begin
        r_key_db <= r_key_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // A press is the cycle in which the debounced level is about to flip 1->0.
  assign w_press = r_key_db && (r_key_sync != r_key_db) && (r_db_cnt == c_CNT_MAX);

  // --------------------------------------------------------------------------
  // Frame boundary detection
  // --------------------------------------------------------------------------
  logic r_fsync_d;
  logic w_frame_tick;

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_fsync_d <= 1'b1;
    else            r_fsync_d <= Fsync;
  end

  assign w_frame_tick = r_fsync_d & ~Fsync;

  // --------------------------------------------------------------------------
  // Mode selection. pending always equals mode unless a press is outstanding,
  // so advancing pending from itself both starts a change (mode+1) and
  // stacks further presses within the same frame.
  // --------------------------------------------------------------------------
  logic [1:0] r_pending;

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode      <= 2'd0;
      r_pending <= 2'd0;
    end else begin
      if (w_frame_tick) mode <= r_pending;
      if (w_press)      r_pending <= r_pending + 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Bouncing box position; runs in every mode. Direction flag: 0 = +, 1 = -.
  // Result packs {next_dir, next_pos}.
  // --------------------------------------------------------------------------
  function automatic logic [10:0] f_step(input logic [9:0] pos, input logic dir_neg,
                                         input logic [10:0] limit);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!dir_neg) begin
      if (p + c_STEP >= limit) f_step = {1'b1, limit[9:0]};
      else                     f_step = {1'b0, pos + c_STEP[9:0]};
    end else begin
      if (p <= c_STEP)         f_step = {1'b0, 10'd0};
      else                     f_step = {1'b1, pos - c_STEP[9:0]};
    end
  endfunction

  logic [9:0]  r_box_x;
  logic [9:0]  r_box_y;
  logic        r_dir_x_neg;
  logic        r_dir_y_neg;
  logic [10:0] w_next_x;
  logic [10:0] w_next_y;

  assign w_next_x = f_step(r_box_x, r_dir_x_neg, c_LIMIT_X);
  assign w_next_y = f_step(r_box_y, r_dir_y_neg, c_LIMIT_Y);

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_box_x     <= 10'd0;
      r_box_y     <= 10'd0;
      r_dir_x_neg <= 1'b0;
      r_dir_y_neg <= 1'b0;
    end else if (w_frame_tick) begin
      r_box_x     <= w_next_x[9:0];
      r_dir_x_neg <= w_next_x[10];
      r_box_y     <= w_next_y[9:0];
      r_dir_y_neg <= w_next_y[10];
    end
  end

  // --------------------------------------------------------------------------
  // Pattern generation
  // --------------------------------------------------------------------------
  logic        w_active;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic [2:0]  w_bar;
  logic [2:0]  w_bar_bits;
  logic [29:0] w_bars_rgb;
  logic [29:0] w_check_rgb;
  logic [9:0]  w_level;
  logic        w_in_box;
  logic [29:0] w_box_rgb;
  logic [29:0] w_pix_next;

  assign w_active = (pixel_xpos != 10'd0) && (pixel_ypos != 10'd0);
  assign w_x      = pixel_xpos - 10'd1;
  assign w_y      = pixel_ypos - 10'd1;

  // Bar index = x / c_BAR_W, done with threshold compares instead of a divider.
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(w_x) >= i * c_BAR_W) w_bar = 3'(i);
    end
  end

  // {R,G,B} on/off bits in the classic bar order.
  always_comb begin
    w_bar_bits = 3'b000;
    case (w_bar)
      3'd0: w_bar_bits = 3'b111;  // white
      3'd1: w_bar_bits = 3'b110;  // yellow
      3'd2: w_bar_bits = 3'b011;  // cyan
      3'd3: w_bar_bits = 3'b010;  // green
      3'd4: w_bar_bits = 3'b101;  // magenta
      3'd5: w_bar_bits = 3'b100;  // red
      3'd6: w_bar_bits = 3'b001;  // blue
      default: w_bar_bits = 3'b000;  // black
    endcase
  end

  assign w_bars_rgb  = {{10{w_bar_bits[2]}}, {10{w_bar_bits[1]}}, {10{w_bar_bits[0]}}};
  assign w_check_rgb = (w_x[5] ^ w_y[5]) ? {3{c_FULL}} : 30'd0;

  // x * 1.5 kept to 10 bits; peaks at 958 on the last column.
  assign w_level = w_x + {1'b0, w_x[9:1]};

  assign w_in_box = ({1'b0, w_x} >= {1'b0, r_box_x}) && ({1'b0, w_x} < {1'b0, r_box_x} + c_SIZE) &&
                    ({1'b0, w_y} >= {1'b0, r_box_y}) && ({1'b0, w_y} < {1'b0, r_box_y} + c_SIZE);
  assign w_box_rgb = w_in_box ? {c_FULL, 10'd0, 10'd0} : {10'd0, 10'd0, c_FULL};

  always_comb begin
    w_pix_next = 30'd0;
    if (w_active) begin
      case (mode)
        2'd0:    w_pix_next = w_bars_rgb;
        2'd1:    w_pix_next = w_check_rgb;
        2'd2:    w_pix_next = {w_level, w_level, w_level};
        default: w_pix_next = w_box_rgb;
      endcase
    end
  end

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) data_from_display <= 30'd0;
    else            data_from_display <= w_pix_next;
  end

endmodule
`default_nettype wire
